tx_mask_upsampler: RTL

Parametrised M-ASK transmit front end: buffers incoming symbols, Gray-maps them to signed levels scaled by a runtime reference, and upsamples by UP_FACTOR. Generates its own sam_clk_en/sym_clk_en from sys_clk, so downstream SRRC/halfband stages take their enables from this block instead of tying them to sys_clk. It replaces the fixed 4-ASK mapper plus x4 upsampler pair at the head of the TX chain.

---
 rtl/tx_mask_upsampler.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/tx_mask_upsampler.sv
// ---------------------------------------------------------------------------
// tx_mask_upsampler
//
// M-ASK transmit front end. Incoming Gray-coded symbols are buffered in a
// small FIFO. On every symbol boundary the head symbol is Gray-decoded and
// mapped to a signed level, (2k-(M-1))*ref_level, saturated to DATA_W bits.
// The result is then upsampled by UP_FACTOR. The block generates its own
// sample and symbol strobes from sys_clk. Downstream filter stages take
// their clock enables from these strobes.
//
// Optional feature (compile-time macro TX_ZOH_EN):
//   undefined : zero stuffing. Non-boundary samples of tx_up are 0.
//   defined   : zero-order hold. Non-boundary samples repeat tx_sym.
// Ports and strobe cadence are the same in both builds.
//
// Ports:
//   sys_clk     in   system clock, all logic on the rising edge
//   reset       in   asynchronous, active-low reset
//   enable      in   run enable for the strobe counters and the datapath
//   sym_in      in   Gray-coded symbol, BITS_PER_SYM bits
//   sym_valid   in   sym_in valid
//   sym_ready   out  FIFO can accept a symbol (not full)
//   ref_level   in   unsigned half level spacing, held static while running
//   sam_clk_en  out  one-cycle sample strobe
//   sym_clk_en  out  one-cycle symbol strobe, always coincident with sam_clk_en
//   tx_sym      out  signed mapped level of the current symbol
//   tx_up       out  signed upsampled stream
//   fifo_level  out  FIFO occupancy
//   underflow   out  sticky: a symbol boundary found the FIFO empty
//
// Handshake: a symbol is transferred on every rising edge where
// sym_valid && sym_ready are both high. sym_ready does not depend on
// sym_valid. While sym_valid is high, sym_in must stay stable until the
// transfer happens.
// ---------------------------------------------------------------------------
module tx_mask_upsampler #(
  parameter int DATA_W       = 18,
  parameter int BITS_PER_SYM = 2,
  parameter int UP_FACTOR    = 4,
  parameter int SYS_PER_SAM  = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                            sys_clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [BITS_PER_SYM-1:0]         sym_in,
  input  logic                            sym_valid,
  output logic                            sym_ready,
  input  logic [DATA_W-1:0]               ref_level,
  output logic                            sam_clk_en,
  output logic                            sym_clk_en,
  output logic signed [DATA_W-1:0]        tx_sym,
  output logic signed [DATA_W-1:0]        tx_up,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            underflow
);

  localparam int M     = 2 ** BITS_PER_SYM;
  localparam int CNT_W = $clog2(SYS_PER_SAM);
  localparam int PH_W  = $clog2(UP_FACTOR);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  // Level coefficient 2k-(M-1) lies in -(M-1)..(M-1).
  localparam int CW    = BITS_PER_SYM + 2;
  // Full-width product: |coef| < 2^(B+1) and ref_level < 2^DATA_W.
  localparam int PW    = DATA_W + BITS_PER_SYM + 2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYS_PER_SAM - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [CW-1:0]    COEF_OFS = CW'(M - 1);

  localparam logic signed [PW-1:0] SAT_MAX =
    {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN =
    {{(PW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  // ------------------------------------------------------------------
  // Strobe generation
  // ------------------------------------------------------------------
  logic [CNT_W-1:0] sam_cnt;
  logic [PH_W-1:0]  phase;

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      sam_cnt <= '0;
    end else if (enable) begin
      sam_cnt <= (sam_cnt == CNT_LAST) ? '0 : sam_cnt + CNT_W'(1);
    end
  end

  // UP_FACTOR is a power of two, so phase wraps naturally.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      phase <= '0;
    end else if (sam_clk_en) begin
      phase <= phase + PH_W'(1);
    end
  end

  // Both strobes are decoded from registers, gated only by enable.
  assign sam_clk_en = enable && (sam_cnt == CNT_LAST);
  assign sym_clk_en = sam_clk_en && (phase == '0);

  // ------------------------------------------------------------------
  // Symbol FIFO
  // ------------------------------------------------------------------
  logic [BITS_PER_SYM-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic                    fifo_empty;
  logic                    push;
  logic                    pop;

  assign fifo_empty = (fifo_level == '0);
  assign sym_ready  = (fifo_level != LVL_FULL);
  assign push       = sym_valid && sym_ready;
  // No bypass: a symbol pushed on a boundary cycle is not available to
  // that boundary.
  assign pop        = sym_clk_en && !fifo_empty;

  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem[wr_ptr] <= sym_in;
    end
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Gray decode and level mapping of the FIFO head
  // ------------------------------------------------------------------
  logic [BITS_PER_SYM-1:0]   head_gray;
  logic [BITS_PER_SYM-1:0]   head_bin;
  logic signed [CW-1:0]      coef;
  logic signed [PW-1:0]      coef_x;
  logic signed [PW-1:0]      ref_x;
  logic signed [PW-1:0]      prod;
  logic signed [DATA_W-1:0]  head_level;

  assign head_gray = mem[rd_ptr];

  always_comb begin
    // Binary bit i is the XOR of all Gray bits at or above i.
    head_bin = head_gray;
    for (int i = BITS_PER_SYM - 2; i >= 0; i--) begin
      head_bin[i] = head_bin[i+1] ^ head_gray[i];
    end
  end

  always_comb begin
    coef   = $signed({1'b0, head_bin, 1'b0}) - $signed(COEF_OFS);
    coef_x = {{(PW-CW){coef[CW-1]}}, coef};
    ref_x  = {{(PW-DATA_W){1'b0}}, ref_level};
    prod   = coef_x * ref_x;
    if (prod > SAT_MAX) begin
      head_level = SAT_MAX[DATA_W-1:0];
    end else if (prod < SAT_MIN) begin
      head_level = SAT_MIN[DATA_W-1:0];
    end else begin
      head_level = prod[DATA_W-1:0];
    end
  end

  // ------------------------------------------------------------------
  // Output stage
  // ------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      tx_sym    <= '0;
      tx_up     <= '0;
      underflow <= 1'b0;
    end else if (sym_clk_en) begin
      if (!fifo_empty) begin
        tx_sym <= head_level;
        tx_up  <= head_level;
      end else begin
        // Starved boundary: emit silence for the whole symbol.
        tx_sym    <= '0;
        tx_up     <= '0;
        underflow <= 1'b1;
      end
    end else if (sam_clk_en) begin
`ifdef TX_ZOH_EN
      tx_up <= tx_sym;
`else
      tx_up <= '0;
`endif
    end
  end

endmodule
